// File: rtl/mod_n_counter.sv
`default_nettype none
// ============================================================================
//  Module   : mod_n_counter
//  Purpose  : Synchronous modulo-N up/down counter with parallel load,
//             saturate mode and a combinational terminal count for cascading.
//  Revision : 1.0  initial release
// ============================================================================
module mod_n_counter #(
   parameter int unsigned WIDTH       = 4,
   parameter int unsigned MODULUS     = 10,
   parameter int unsigned RESET_VALUE = 0
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             sat,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             wrap,
   output logic             load_err
);

   localparam logic [WIDTH-1:0] MAX_VAL   = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] RST_VAL   = WIDTH'(RESET_VALUE);
   localparam logic [WIDTH:0]   MOD_EXT   = (WIDTH+1)'(MODULUS);

   generate
      if ((MODULUS < 2) || (64'(MODULUS) > (64'd1 << WIDTH)) ||
          (RESET_VALUE >= MODULUS)) begin : g_bad_params
         $error("mod_n_counter: illegal WIDTH/MODULUS/RESET_VALUE combination");
      end
   endgenerate

   logic [WIDTH-1:0] count_q, count_d;
   logic             wrap_q, wrap_d;
   logic             load_err_q, load_err_d;
   logic             load_ok;
   logic             at_max, at_zero;

   // Zero-extend by one bit so MODULUS = 2^WIDTH still compares correctly.
   assign load_ok = ({1'b0, load_val} < MOD_EXT);
   assign at_max  = (count_q == MAX_VAL);
   assign at_zero = (count_q == '0);

   always_comb begin
      count_d    = count_q;
      wrap_d     = 1'b0;
      load_err_d = 1'b0;
      if (load) begin
         if (load_ok) begin
            count_d = load_val;
         end else begin
            load_err_d = 1'b1;
         end
      end else if (en) begin
         if (up) begin
            if (at_max) begin
               if (!sat) begin
                  count_d = '0;
                  wrap_d  = 1'b1;
               end
            end else begin
               count_d = count_q + 1'b1;
            end
         end else begin
            if (at_zero) begin
               if (!sat) begin
                  count_d = MAX_VAL;
                  wrap_d  = 1'b1;
               end
            end else begin
               count_d = count_q - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         count_q    <= RST_VAL;
         wrap_q     <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         count_q    <= count_d;
         wrap_q     <= wrap_d;
         load_err_q <= load_err_d;
      end
   end

   // Terminal count stays combinational so a cascaded stage advances on the same edge.
   assign tc       = en & (up ? at_max : at_zero);
   assign q        = count_q;
   assign wrap     = wrap_q;
   assign load_err = load_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mod_n_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mod_n_counter
//  Purpose  : Directed self-checking bench for mod_n_counter.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mod_n_counter;

   logic       clk = 1'b0;
   logic       clear = 1'b0;
   logic       en = 1'b0, up = 1'b1, load = 1'b0, sat = 1'b0;
   logic [3:0] load_val = '0;
   logic [3:0] q, q_rv3;
   logic       tc, wrap, load_err, tc_rv3, wrap_rv3, lerr_rv3;

   logic       c_clear = 1'b0;
   logic       c_en = 1'b0;
   logic [3:0] q_lo, q_hi, q_m16;
   logic       tc_lo, tc_hi, tc_m16, wrap_lo, wrap_hi, wrap_m16;
   logic       lerr_lo, lerr_hi, lerr_m16;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mod_n_counter #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(0)) u_dut (
      .clk(clk), .clear(clear), .en(en), .up(up), .load(load), .load_val(load_val),
      .sat(sat), .q(q), .tc(tc), .wrap(wrap), .load_err(load_err));

   mod_n_counter #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(3)) u_rv3 (
      .clk(clk), .clear(clear), .en(en), .up(up), .load(load), .load_val(load_val),
      .sat(sat), .q(q_rv3), .tc(tc_rv3), .wrap(wrap_rv3), .load_err(lerr_rv3));

   mod_n_counter #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(0)) u_lo (
      .clk(clk), .clear(c_clear), .en(c_en), .up(1'b1), .load(1'b0), .load_val(4'd0),
      .sat(1'b0), .q(q_lo), .tc(tc_lo), .wrap(wrap_lo), .load_err(lerr_lo));

   mod_n_counter #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(0)) u_hi (
      .clk(clk), .clear(c_clear), .en(tc_lo), .up(1'b1), .load(1'b0), .load_val(4'd0),
      .sat(1'b0), .q(q_hi), .tc(tc_hi), .wrap(wrap_hi), .load_err(lerr_hi));

   mod_n_counter #(.WIDTH(4), .MODULUS(16), .RESET_VALUE(0)) u_m16 (
      .clk(clk), .clear(c_clear), .en(c_en), .up(1'b1), .load(1'b0), .load_val(4'd0),
      .sat(1'b0), .q(q_m16), .tc(tc_m16), .wrap(wrap_m16), .load_err(lerr_m16));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #1 clear = 1'b1; c_clear = 1'b1;
      #1;
      checks++; if (q !== 4'd0) begin errors++; $display("FAIL reset_q got=%0d exp=0", q); end
      checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap got=%b exp=0", wrap); end
      checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL reset_lerr got=%b exp=0", load_err); end
      checks++; if (tc !== 1'b0) begin errors++; $display("FAIL reset_tc got=%b exp=0", tc); end
      checks++; if (q_rv3 !== 4'd3) begin errors++; $display("FAIL reset_rv3_q got=%0d exp=3", q_rv3); end
      tick();
   endtask

   task automatic test_up_count();
      clear = 1'b0; en = 1'b1; up = 1'b1; sat = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         checks++; if (q !== 4'((i + 1) % 10)) begin errors++; $display("FAIL up_q edge=%0d got=%0d exp=%0d", i + 1, q, (i + 1) % 10); end
         checks++; if (tc !== (((i + 1) % 10) == 9)) begin errors++; $display("FAIL up_tc edge=%0d got=%b", i + 1, tc); end
         checks++; if (wrap !== (i == 9)) begin errors++; $display("FAIL up_wrap edge=%0d got=%b exp=%b", i + 1, wrap, i == 9); end
      end
   endtask

   task automatic test_down_count();
      en = 1'b0; clear = 1'b1; tick(); clear = 1'b0;
      en = 1'b1; up = 1'b0;
      #1;
      checks++; if (tc !== 1'b1) begin errors++; $display("FAIL down_tc_at0 got=%b exp=1", tc); end
      tick();
      checks++; if (q !== 4'd9) begin errors++; $display("FAIL down_q1 got=%0d exp=9", q); end
      checks++; if (wrap !== 1'b1) begin errors++; $display("FAIL down_wrap1 got=%b exp=1", wrap); end
      checks++; if (tc !== 1'b0) begin errors++; $display("FAIL down_tc_at9 got=%b exp=0", tc); end
      tick();
      checks++; if (q !== 4'd8) begin errors++; $display("FAIL down_q2 got=%0d exp=8", q); end
      checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL down_wrap2 got=%b exp=0", wrap); end
      tick();
      checks++; if (q !== 4'd7) begin errors++; $display("FAIL down_q3 got=%0d exp=7", q); end
   endtask

   task automatic test_load();
      en = 1'b0; up = 1'b1; load = 1'b1; load_val = 4'd7;
      tick();
      checks++; if (q !== 4'd7) begin errors++; $display("FAIL load7_q got=%0d exp=7", q); end
      checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL load7_err got=%b exp=0", load_err); end
      load_val = 4'd12;
      tick();
      checks++; if (q !== 4'd7) begin errors++; $display("FAIL load12_q got=%0d exp=7", q); end
      checks++; if (load_err !== 1'b1) begin errors++; $display("FAIL load12_err got=%b exp=1", load_err); end
      load = 1'b0;
      tick();
      checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL lerr_pulse got=%b exp=0", load_err); end
      load = 1'b1; load_val = 4'd9;
      tick();
      load_val = 4'd3; en = 1'b1;
      #1;
      checks++; if (tc !== 1'b1) begin errors++; $display("FAIL load_en_tc got=%b exp=1", tc); end
      tick();
      checks++; if (q !== 4'd3) begin errors++; $display("FAIL load_en_q got=%0d exp=3", q); end
      checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL load_en_wrap got=%b exp=0", wrap); end
   endtask

   task automatic test_saturate();
      en = 1'b0; load = 1'b1; load_val = 4'd8;
      tick();
      load = 1'b0; en = 1'b1; up = 1'b1; sat = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (q !== 4'd9) begin errors++; $display("FAIL sat_q edge=%0d got=%0d exp=9", i, q); end
         checks++; if (tc !== 1'b1) begin errors++; $display("FAIL sat_tc edge=%0d got=%b exp=1", i, tc); end
         checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL sat_wrap edge=%0d got=%b exp=0", i, wrap); end
      end
      up = 1'b0;
      tick();
      checks++; if (q !== 4'd8) begin errors++; $display("FAIL sat_down_q got=%0d exp=8", q); end
      sat = 1'b0;
   endtask

   task automatic test_async_reset();
      en = 1'b0; load = 1'b1; load_val = 4'd5;
      tick();
      load = 1'b0;
      #2 clear = 1'b1;
      #1;
      checks++; if (q !== 4'd0) begin errors++; $display("FAIL areset_q got=%0d exp=0", q); end
      checks++; if (q_rv3 !== 4'd3) begin errors++; $display("FAIL areset_rv3 got=%0d exp=3", q_rv3); end
      load = 1'b1; load_val = 4'd6;
      tick();
      checks++; if (q !== 4'd0) begin errors++; $display("FAIL areset_load got=%0d exp=0", q); end
      clear = 1'b0; load = 1'b0;
      tick();
      checks++; if (q !== 4'd0) begin errors++; $display("FAIL areset_hold got=%0d exp=0", q); end
      en = 1'b1; up = 1'b0;
      tick();
      checks++; if (wrap !== 1'b1) begin errors++; $display("FAIL pre_clear_wrap got=%b exp=1", wrap); end
      en = 1'b0;
      #2 clear = 1'b1;
      #1;
      checks++; if (q !== 4'd0) begin errors++; $display("FAIL areset2_q got=%0d exp=0", q); end
      checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL areset2_wrap got=%b exp=0", wrap); end
      tick();
      clear = 1'b0;
   endtask

   task automatic test_cascade();
      int hi_wraps = 0;
      c_clear = 1'b0; c_en = 1'b1;
      for (int k = 1; k <= 100; k++) begin
         tick();
         if (wrap_hi === 1'b1) hi_wraps++;
         checks++; if ((q_hi * 10 + q_lo) !== ((k % 100))) begin errors++; $display("FAIL cascade edge=%0d got=%0d%0d exp=%0d", k, q_hi, q_lo, k % 100); end
         checks++; if (q_m16 !== 4'(k % 16)) begin errors++; $display("FAIL m16_q edge=%0d got=%0d exp=%0d", k, q_m16, k % 16); end
         checks++; if (wrap_m16 !== ((k % 16) == 0)) begin errors++; $display("FAIL m16_wrap edge=%0d got=%b", k, wrap_m16); end
      end
      checks++; if (hi_wraps !== 1) begin errors++; $display("FAIL hi_wrap_count got=%0d exp=1", hi_wraps); end
      c_en = 1'b0;
   endtask

   initial begin
      test_reset();
      test_up_count();
      test_down_count();
      test_load();
      test_saturate();
      test_async_reset();
      test_cascade();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
